rsa_decrypt: RTL and testbench



---
 rtl/rsa_decrypt.sv | 152 +++++++++++++++
 tb/tb_rsa_decrypt.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/rsa_decrypt.sv
// rsa_decrypt: toy RSA receive side. Computes plain = cipher^D mod N with
// right-to-left square-and-multiply, one modular step per clock. Every job
// takes the same number of cycles whatever the data, so output timing
// reveals nothing about the ciphertext.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   ciphertext handshake; in_ready only in IDLE
//   cipher [WIDTH]        ciphertext word
//   out_valid / out_ready plaintext handshake; plain held until consumed
//   plain [WIDTH]         decrypted word, keeps its value after consumption
//   busy                  high whenever the FSM is not in IDLE
//   cipher_oor            (only with RSA_RANGE_CHK_EN) the accepted cipher
//                         was >= N; meaningful only while out_valid=1
//
// Optional macro: RSA_RANGE_CHK_EN adds the cipher_oor flag.
module rsa_decrypt #(
  parameter int WIDTH    = 8,
  parameter int N        = 33,
  parameter int D        = 7,
  parameter int EXP_BITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] cipher,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] plain,
`ifdef RSA_RANGE_CHK_EN
  output logic             cipher_oor,
`endif
  output logic             busy
);

  localparam int CW = $clog2(EXP_BITS) + 1;
  localparam logic [2*WIDTH-1:0] N_2W = (2*WIDTH)'(N);
  // 1 mod N collapses to 0 for the degenerate modulus N=1.
  localparam logic [WIDTH-1:0] ONE_MOD_N = (N == 1) ? '0 : WIDTH'(1);

  typedef enum logic [1:0] {IDLE, REDUCE, EXP, DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     cin_q, cin_d;
  logic [WIDTH-1:0]     base_q, base_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic [EXP_BITS-1:0]  exp_q, exp_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     plain_q, plain_d;
  logic                 ov_q, ov_d;
  logic                 last_step;

  function automatic logic [WIDTH-1:0] mulmod(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] p;
    p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    return WIDTH'(p % N_2W);
  endfunction

  assign last_step = (cnt_q == CW'(EXP_BITS - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = REDUCE;
      REDUCE:  state_d = EXP;
      EXP:     if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs derived from state
  always_comb begin
    in_ready = (state_q == IDLE);
    busy     = (state_q != IDLE);
  end

  // Datapath next-state
  always_comb begin
    cin_d   = cin_q;
    base_d  = base_q;
    res_d   = res_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    plain_d = plain_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE: if (in_valid) cin_d = cipher;
      REDUCE: begin
        base_d = WIDTH'({{WIDTH{1'b0}}, cin_q} % N_2W);
        res_d  = ONE_MOD_N;
        exp_d  = EXP_BITS'(D);
        cnt_d  = '0;
      end
      EXP: begin
        if (exp_q[0]) res_d = mulmod(res_q, base_q);
        base_d = mulmod(base_q, base_q);
        exp_d  = exp_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        // Final result includes this cycle's multiply.
        if (last_step) begin
          plain_d = res_d;
          ov_d    = 1'b1;
        end
      end
      DONE: if (out_ready) ov_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cin_q   <= '0;
      base_q  <= '0;
      res_q   <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
      plain_q <= '0;
      ov_q    <= 1'b0;
    end else begin
      cin_q   <= cin_d;
      base_q  <= base_d;
      res_q   <= res_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      plain_q <= plain_d;
      ov_q    <= ov_d;
    end
  end

  assign plain     = plain_q;
  assign out_valid = ov_q;

`ifdef RSA_RANGE_CHK_EN
  logic oor_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      oor_q <= 1'b0;
    else if (in_valid && in_ready)   oor_q <= ({{WIDTH{1'b0}}, cipher} >= N_2W);
  end
  assign cipher_oor = oor_q;
`endif

endmodule

// File: tb/tb_rsa_decrypt.sv
module tb_rsa_decrypt;
  localparam int W = 8, NM = 33, DE = 7, EB = 8;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         in_valid = 1'b0, out_ready = 1'b1;
  logic [W-1:0] cipher = '0;
  logic         in_ready, out_valid, busy;
  logic [W-1:0] plain;
`ifdef RSA_RANGE_CHK_EN
  logic         cipher_oor;
`endif

  int checks = 0, failures = 0;

  rsa_decrypt #(.WIDTH(W), .N(NM), .D(DE), .EXP_BITS(EB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .cipher(cipher), .out_valid(out_valid), .out_ready(out_ready),
    .plain(plain),
`ifdef RSA_RANGE_CHK_EN
    .cipher_oor(cipher_oor),
`endif
    .busy(busy));

  always #5 clk = ~clk;

  // Reference: c^D mod N by repeated multiplication.
  function automatic int ref_pow(input int c);
    int b, r;
    b = c % NM;
    r = 1 % NM;
    for (int i = 0; i < DE; i++) r = (r * b) % NM;
    return r;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present c, wait for acceptance, check latency and result.
  // With out_ready=0 the task returns while the result is being held.
  task automatic do_job(input logic [W-1:0] c, input string tag);
    int w, lat;
    logic busy_ok;
    in_valid = 1'b1;
    cipher   = c;
    w = 0;
    while (!in_ready && w < 100) begin tick; w++; end
    chk({tag, "_accept_timeout"}, int'(w < 100), 1);
    tick;                       // accept edge
    in_valid = 1'b0;
    chk({tag, "_in_ready_low"}, int'(in_ready), 0);
    lat = 0;
    busy_ok = 1'b1;
    while (!out_valid && lat < 50) begin
      if (!busy) busy_ok = 1'b0;
      tick;
      lat++;
    end
    chk({tag, "_latency"}, lat, EB + 1);
    chk({tag, "_busy"}, int'(busy_ok && busy), 1);
    chk({tag, "_plain"}, int'(plain), ref_pow(int'(c)));
`ifdef RSA_RANGE_CHK_EN
    chk({tag, "_oor"}, int'(cipher_oor), int'(int'(c) >= NM));
`endif
    if (out_ready) begin
      tick;
      chk({tag, "_consumed"}, int'(out_valid), 0);
    end
  endtask

  initial begin
    logic [W-1:0] held;
    #12;
    chk("rst_plain", int'(plain), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    tick;

    do_job(8'd18, "c18");
    chk("c18_const", int'(plain), 6);
    do_job(8'd0, "c0");
    do_job(8'd1, "c1");
    do_job(8'd27, "c27");
    chk("c27_const", int'(plain), 3);
    do_job(8'd255, "c255");
    chk("c255_const", int'(plain), 18);
    do_job(8'd32, "c32");

    // Backpressure: result and flags must hold, new input ignored.
    out_ready = 1'b0;
    do_job(8'd20, "bp");
    held = plain;
    in_valid = 1'b1;
    cipher   = 8'd5;
    for (int i = 0; i < 20; i++) begin
      tick;
      chk("bp_valid_hold", int'(out_valid), 1);
      chk("bp_plain_hold", int'(plain), int'(held));
      chk("bp_in_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick;
    chk("bp_release_valid", int'(out_valid), 0);
    chk("bp_release_ready", int'(in_ready), 1);
    chk("bp_plain_kept", int'(plain), int'(held));

    // Asynchronous reset in the middle of EXP.
    in_valid = 1'b1;
    cipher   = 8'd27;
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_plain", int'(plain), 0);
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    chk("arst_busy", int'(busy), 0);
    #1 rst_n = 1'b1;
    tick;
    do_job(8'd18, "post_rst");

    // Full in-range sweep, then random words.
    for (int c = 0; c < NM; c++) do_job(W'(c), "sweep");
    for (int i = 0; i < 12; i++) do_job(W'($urandom_range(0, 255)), "rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
